// File: rtl/nios2_qsys_oci_dct_packer.sv
// rtl/nios2_qsys_oci_dct_packer.sv - packs 2-bit trace atoms into 30-bit frames of up to 15 atoms
// Optional feature macro: DCT_OVERFLOW_CNT_EN (adds the saturating dropped-atom counter dct_ovf_cnt)
module nios2_qsys_oci_dct_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        atm_valid,
  input  logic [1:0]  atm_data,
  input  logic        flush,
  input  logic        frm_ready,
  output logic        frm_valid,
  output logic [29:0] frm_data,
  output logic [3:0]  frm_count,
  output logic [29:0] dct_buffer,
`ifdef DCT_OVERFLOW_CNT_EN
  output logic [3:0]  dct_count,
  output logic [7:0]  dct_ovf_cnt
`else
  output logic [3:0]  dct_count
`endif
);

  logic [29:0] buf_q, buf_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        frm_valid_q, frm_valid_d;
  logic [29:0] frm_data_q, frm_data_d;
  logic [3:0]  frm_count_q, frm_count_d;
  logic        flush_pend_q, flush_pend_d;
  logic        flush_req, want, hold_free, drop;
`ifdef DCT_OVERFLOW_CNT_EN
  logic [7:0]  ovf_q, ovf_d;
`endif

  // Request terms: a frame is wanted when full, or when a flush is outstanding on a non-empty buffer
  always_comb begin
    flush_req = flush | flush_pend_q;
    want      = (cnt_q == 4'd15) | (flush_req & (cnt_q != 4'd0));
    hold_free = ~frm_valid_q | frm_ready;
    drop      = want & ~hold_free & atm_valid & (cnt_q == 4'd15);
  end

  // Next-state for accumulator, holding register and pending flush
  always_comb begin
    buf_d        = buf_q;
    cnt_d        = cnt_q;
    frm_valid_d  = frm_valid_q;
    frm_data_d   = frm_data_q;
    frm_count_d  = frm_count_q;
    flush_pend_d = flush_pend_q;
    if (want & hold_free) begin
      // Transfer: a same-cycle atom starts the new buffer rather than joining the frame
      frm_data_d   = buf_q;
      frm_count_d  = cnt_q;
      frm_valid_d  = 1'b1;
      flush_pend_d = 1'b0;
      buf_d        = atm_valid ? {28'b0, atm_data} : 30'b0;
      cnt_d        = atm_valid ? 4'd1 : 4'd0;
    end else begin
      if (frm_valid_q & frm_ready) begin
        frm_valid_d = 1'b0;
      end
      if (want) begin
        // Holding register busy: keep the flush alive, append while room remains
        flush_pend_d = flush_req;
        if (atm_valid && (cnt_q != 4'd15)) begin
          buf_d = {buf_q[27:0], atm_data};
          cnt_d = cnt_q + 4'd1;
        end
      end else begin
        // Nothing to frame: a flush on an empty buffer is discarded
        flush_pend_d = 1'b0;
        if (atm_valid) begin
          buf_d = {buf_q[27:0], atm_data};
          cnt_d = cnt_q + 4'd1;
        end
      end
    end
  end

`ifdef DCT_OVERFLOW_CNT_EN
  // Saturating count of atoms lost while both accumulator and holding register are full
  always_comb begin
    ovf_d = ovf_q;
    if (drop && (ovf_q != 8'hFF)) begin
      ovf_d = ovf_q + 8'd1;
    end
  end

  // Overflow counter register, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 8'd0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign dct_ovf_cnt = ovf_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q        <= 30'b0;
      cnt_q        <= 4'd0;
      frm_valid_q  <= 1'b0;
      frm_data_q   <= 30'b0;
      frm_count_q  <= 4'd0;
      flush_pend_q <= 1'b0;
    end else begin
      buf_q        <= buf_d;
      cnt_q        <= cnt_d;
      frm_valid_q  <= frm_valid_d;
      frm_data_q   <= frm_data_d;
      frm_count_q  <= frm_count_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign frm_valid  = frm_valid_q;
  assign frm_data   = frm_data_q;
  assign frm_count  = frm_count_q;
  assign dct_buffer = buf_q;
  assign dct_count  = cnt_q;

endmodule

// File: tb/tb_nios2_qsys_oci_dct_packer.sv
// tb/tb_nios2_qsys_oci_dct_packer.sv - self-checking bench for nios2_qsys_oci_dct_packer
module tb_nios2_qsys_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        atm_valid = 1'b0;
  logic [1:0]  atm_data = 2'b0;
  logic        flush = 1'b0;
  logic        frm_ready = 1'b0;
  logic        frm_valid;
  logic [29:0] frm_data;
  logic [3:0]  frm_count;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
`ifdef DCT_OVERFLOW_CNT_EN
  logic [7:0]  dct_ovf_cnt;
`endif

  nios2_qsys_oci_dct_packer dut (
    .clk        (clk),
    .reset      (reset),
    .atm_valid  (atm_valid),
    .atm_data   (atm_data),
    .flush      (flush),
    .frm_ready  (frm_ready),
    .frm_valid  (frm_valid),
    .frm_data   (frm_data),
    .frm_count  (frm_count),
    .dct_buffer (dct_buffer),
`ifdef DCT_OVERFLOW_CNT_EN
    .dct_count  (dct_count),
    .dct_ovf_cnt(dct_ovf_cnt)
`else
    .dct_count  (dct_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: accumulator as a queue of atoms (oldest first) plus a holding register
  logic [1:0] m_acc[$];
  bit         m_pend;
  bit         m_hv;
  logic [29:0] m_hd;
  int         m_hc;
  int         m_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [29:0] packed_acc();
    logic [29:0] v = 30'b0;
    foreach (m_acc[i]) v = (v << 2) | {28'b0, m_acc[i]};
    return v;
  endfunction

  task automatic model_step(input bit rst, input bit av, input logic [1:0] ad,
                            input bit fl, input bit rdy);
    bit freq, want, free;
    if (rst) begin
      m_acc.delete(); m_pend = 0; m_hv = 0; m_hd = 0; m_hc = 0; m_ovf = 0;
      return;
    end
    freq = fl || m_pend;
    want = (m_acc.size() == 15) || (freq && m_acc.size() > 0);
    free = !m_hv || rdy;
    if (want && free) begin
      m_hd = packed_acc(); m_hc = m_acc.size(); m_hv = 1; m_pend = 0;
      m_acc.delete();
      if (av) m_acc.push_back(ad);
    end else begin
      if (m_hv && rdy) m_hv = 0;
      if (want) begin
        m_pend = freq;
        if (av) begin
          if (m_acc.size() < 15) m_acc.push_back(ad);
          else if (m_ovf < 255) m_ovf++;
        end
      end else begin
        m_pend = 0;
        if (av) m_acc.push_back(ad);
      end
    end
  endtask

  task automatic compare_all();
    check("frm_valid", {31'b0, frm_valid}, {31'b0, m_hv});
    if (m_hv) begin
      check("frm_data", {2'b0, frm_data}, {2'b0, m_hd});
      check("frm_count", {28'b0, frm_count}, m_hc);
    end
    check("dct_buffer", {2'b0, dct_buffer}, {2'b0, packed_acc()});
    check("dct_count", {28'b0, dct_count}, m_acc.size());
`ifdef DCT_OVERFLOW_CNT_EN
    check("dct_ovf_cnt", {24'b0, dct_ovf_cnt}, m_ovf);
`endif
  endtask

  // One clock: drive inputs, advance model at the edge, compare shortly after
  task automatic cyc(input bit rst, input bit av, input logic [1:0] ad, input bit fl, input bit rdy);
    reset = rst; atm_valid = av; atm_data = ad; flush = fl; frm_ready = rdy;
    @(posedge clk);
    model_step(rst, av, ad, fl, rdy);
    #1;
    compare_all();
  endtask

  logic [1:0] seq3[3];

  initial begin
    // Reset state
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    check("rst_frm_valid", {31'b0, frm_valid}, 0);
    check("rst_dct_count", {28'b0, dct_count}, 0);
    check("rst_frm_data", {2'b0, frm_data}, 0);

    // Full frame of fifteen 01 atoms
    for (int i = 0; i < 15; i++) begin
      cyc(0, 1, 2'b01, 0, 1);
      check("t1_count_step", {28'b0, dct_count}, i + 1);
    end
    cyc(0, 0, 0, 0, 1);
    check("t1_frm_valid", {31'b0, frm_valid}, 1);
    check("t1_frm_data", {2'b0, frm_data}, 32'h15555555);
    check("t1_frm_count", {28'b0, frm_count}, 15);
    check("t1_dct_count", {28'b0, dct_count}, 0);

    // 11,10,01 then flush
    seq3[0] = 2'b11; seq3[1] = 2'b10; seq3[2] = 2'b01;
    for (int i = 0; i < 3; i++) cyc(0, 1, seq3[i], 0, 1);
    cyc(0, 0, 0, 1, 1);
    check("t2_frm_data", {2'b0, frm_data}, 32'h39);
    check("t2_frm_count", {28'b0, frm_count}, 3);
    check("t2_dct_count", {28'b0, dct_count}, 0);

    // Flush with a same-cycle atom
    cyc(0, 1, 2'b11, 0, 1);
    cyc(0, 1, 2'b10, 0, 1);
    cyc(0, 1, 2'b01, 1, 1);
    check("t3_frm_data", {2'b0, frm_data}, 32'hE);
    check("t3_frm_count", {28'b0, frm_count}, 2);
    check("t3_dct_buffer", {2'b0, dct_buffer}, 32'h1);
    check("t3_dct_count", {28'b0, dct_count}, 1);

    // Flush on an empty buffer never produces a frame
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 1);
    check("t4_no_frame", {31'b0, frm_valid}, 0);
    cyc(0, 1, 2'b10, 0, 1);
    cyc(0, 0, 0, 0, 1);
    check("t4_atom_alone", {31'b0, frm_valid}, 0);
    check("t4_count", {28'b0, dct_count}, 1);

    // Backpressure with 31 atoms: one drop
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 31; i++) cyc(0, 1, 2'($urandom), 0, 0);
    check("t5_frm_valid", {31'b0, frm_valid}, 1);
    check("t5_frm_count", {28'b0, frm_count}, 15);
    check("t5_dct_count", {28'b0, dct_count}, 15);
`ifdef DCT_OVERFLOW_CNT_EN
    check("t5_ovf", {24'b0, dct_ovf_cnt}, 1);
`endif
    cyc(0, 0, 0, 0, 1);
    check("t5_second_count", {28'b0, frm_count}, 15);
    check("t5_second_valid", {31'b0, frm_valid}, 1);

    // Reset mid-frame
    for (int i = 0; i < 7; i++) cyc(0, 1, 2'($urandom), 0, 0);
    check("t6_pre_count", {28'b0, dct_count}, 7);
    cyc(1, 1, 2'b11, 1, 0);
    check("t6_valid", {31'b0, frm_valid}, 0);
    check("t6_count", {28'b0, dct_count}, 0);
    check("t6_buffer", {2'b0, dct_buffer}, 0);
    check("t6_frm_data", {2'b0, frm_data}, 0);
    cyc(0, 1, 2'b10, 0, 1);
    check("t6_after_count", {28'b0, dct_count}, 1);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0), 2'($urandom),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
